// File: rtl/filter_job_ctrl.sv
// -----------------------------------------------------------------------------
// filter_job_ctrl
//
// Per-job sequencer for the 3x3 filter engine. A job (pixel count) is accepted
// first. The controller then takes one 9-tap coefficient bundle from the
// coefficient collector and latches it. It forwards exactly pixel_count pixel
// windows to the MAC stage through a single output register stage, and every
// beat carries the latched coefficients. A done token with the beat total ends
// the job.
//
// Optional build macro: FILTER_JOB_CTRL_STALL_CNT_EN
//   When defined, a saturating 32-bit counter records the cycles in which a MAC
//   beat was held back by mac_ready. Its value is shown on done_stalls while the
//   done token is pending. When undefined, done_stalls is tied to zero and no
//   counter is built.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   job_valid/ready     job request handshake, job_pixel_count = pixels in job
//   coeffs_valid/ready  coefficient bundle handshake, coeffs_data = TAPS signed
//                       coefficients, tap i at [i*COEFF_W +: COEFF_W]
//   win_valid/ready     pixel window handshake, win_data = TAPS unsigned pixels
//   mac_valid/ready     MAC beat handshake; mac_window, mac_coeffs, mac_last
//                       are registered and held stable while mac_valid is high
//   done_valid/ready    job completion handshake; done_count = beats delivered,
//                       done_stalls = backpressure cycles (optional feature)
// -----------------------------------------------------------------------------
module filter_job_ctrl #(
    parameter int CNT_W   = 16,
    parameter int PIX_W   = 8,
    parameter int COEFF_W = 9,
    parameter int TAPS    = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [CNT_W-1:0]         job_pixel_count,
    input  logic                     coeffs_valid,
    output logic                     coeffs_ready,
    input  logic [TAPS*COEFF_W-1:0]  coeffs_data,
    input  logic                     win_valid,
    output logic                     win_ready,
    input  logic [TAPS*PIX_W-1:0]    win_data,
    output logic                     mac_valid,
    input  logic                     mac_ready,
    output logic [TAPS*PIX_W-1:0]    mac_window,
    output logic [TAPS*COEFF_W-1:0]  mac_coeffs,
    output logic                     mac_last,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic [CNT_W-1:0]         done_count,
    output logic [31:0]              done_stalls
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COEFF = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;

    logic [CNT_W-1:0]          remaining_r;
    logic [CNT_W-1:0]          done_count_r;
    logic                      mac_valid_r;
    logic                      mac_last_r;
    logic [TAPS*PIX_W-1:0]     mac_window_r;
    logic [TAPS*COEFF_W-1:0]   mac_coeffs_r;

    logic                      job_ready_s;
    logic                      coeffs_ready_s;
    logic                      win_ready_s;
    logic                      done_valid_s;

    logic                      job_xfer_s;
    logic                      coeff_xfer_s;
    logic                      win_xfer_s;
    logic                      mac_xfer_s;

    // Next-state decode and per-state ready/valid generation.
    always_comb begin
        state_nxt_s    = state_r;
        job_ready_s    = 1'b0;
        coeffs_ready_s = 1'b0;
        win_ready_s    = 1'b0;
        done_valid_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                job_ready_s = 1'b1;
                if (job_valid) begin
                    // Zero-length jobs still pass through COEFF so the bundle is drained.
                    state_nxt_s = ST_COEFF;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COEFF: begin
                coeffs_ready_s = 1'b1;
                if (coeffs_valid) begin
                    if (remaining_r == CNT_ZERO) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_COEFF;
                end
            end
            ST_RUN: begin
                // A window may be loaded when beats remain and the output
                // register is empty or being emptied this cycle.
                win_ready_s = (remaining_r != CNT_ZERO) && (!mac_valid_r || mac_ready);
                if (mac_valid_r && mac_ready && mac_last_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                done_valid_s = 1'b1;
                if (done_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign job_xfer_s   = job_valid    && job_ready_s;
    assign coeff_xfer_s = coeffs_valid && coeffs_ready_s;
    assign win_xfer_s   = win_valid    && win_ready_s;
    assign mac_xfer_s   = mac_valid_r  && mac_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Job counters: remaining beats to forward and beats delivered so far.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_r  <= CNT_ZERO;
            done_count_r <= CNT_ZERO;
        end else if (job_xfer_s) begin
            remaining_r  <= job_pixel_count;
            done_count_r <= CNT_ZERO;
        end else if (win_xfer_s) begin
            // win_ready is only high when remaining is non-zero, so no underflow.
            remaining_r  <= remaining_r - CNT_ONE;
            done_count_r <= done_count_r + CNT_ONE;
        end else begin
            remaining_r  <= remaining_r;
            done_count_r <= done_count_r;
        end
    end

    // Coefficient latch, loaded only by the bundle transfer in COEFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_coeffs_r <= {(TAPS*COEFF_W){1'b0}};
        end else if (coeff_xfer_s) begin
            mac_coeffs_r <= coeffs_data;
        end else begin
            mac_coeffs_r <= mac_coeffs_r;
        end
    end

    // Output register stage: a load and an accept in the same cycle keep
    // mac_valid high, giving one beat per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_valid_r  <= 1'b0;
            mac_last_r   <= 1'b0;
            mac_window_r <= {(TAPS*PIX_W){1'b0}};
        end else if (win_xfer_s) begin
            mac_valid_r  <= 1'b1;
            mac_last_r   <= (remaining_r == CNT_ONE);
            mac_window_r <= win_data;
        end else if (mac_xfer_s) begin
            mac_valid_r  <= 1'b0;
            mac_last_r   <= 1'b0;
            mac_window_r <= mac_window_r;
        end else begin
            mac_valid_r  <= mac_valid_r;
            mac_last_r   <= mac_last_r;
            mac_window_r <= mac_window_r;
        end
    end

`ifdef FILTER_JOB_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of RUN cycles where a pending beat is refused by the MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (job_xfer_s) begin
            stall_cnt_r <= 32'd0;
        end else if ((state_r == ST_RUN) && mac_valid_r && !mac_ready &&
                     (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign done_stalls = (state_r == ST_DONE) ? stall_cnt_r : 32'd0;
`else
    assign done_stalls = 32'd0;
`endif

    assign job_ready    = job_ready_s;
    assign coeffs_ready = coeffs_ready_s;
    assign win_ready    = win_ready_s;
    assign done_valid   = done_valid_s;
    assign mac_valid    = mac_valid_r;
    assign mac_last     = mac_last_r;
    assign mac_window   = mac_window_r;
    assign mac_coeffs   = mac_coeffs_r;
    assign done_count   = done_count_r;

endmodule

// File: tb/tb_filter_job_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filter_job_ctrl
//
// Self-checking bench for filter_job_ctrl. Jobs are driven as directed steps.
// Window data, coefficients and backpressure are randomised. The reference is
// a queue of accepted windows. Each delivered beat must be the oldest
// undelivered window. It must carry the job's coefficients, and the last flag
// must be set only on the beat numbered pixel_count. The pipeline may hold at
// most one pending beat.
// -----------------------------------------------------------------------------
module tb_filter_job_ctrl;

    localparam int CNT_W    = 16;
    localparam int PIX_W    = 8;
    localparam int COEFF_W  = 9;
    localparam int TAPS     = 9;
    localparam int WIN_BITS = TAPS * PIX_W;
    localparam int CF_BITS  = TAPS * COEFF_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 job_valid;
    logic                 job_ready;
    logic [CNT_W-1:0]     job_pixel_count;
    logic                 coeffs_valid;
    logic                 coeffs_ready;
    logic [CF_BITS-1:0]   coeffs_data;
    logic                 win_valid;
    logic                 win_ready;
    logic [WIN_BITS-1:0]  win_data;
    logic                 mac_valid;
    logic                 mac_ready;
    logic [WIN_BITS-1:0]  mac_window;
    logic [CF_BITS-1:0]   mac_coeffs;
    logic                 mac_last;
    logic                 done_valid;
    logic                 done_ready;
    logic [CNT_W-1:0]     done_count;
    logic [31:0]          done_stalls;

    int errors = 0;
    int checks = 0;

    filter_job_ctrl #(
        .CNT_W   (CNT_W),
        .PIX_W   (PIX_W),
        .COEFF_W (COEFF_W),
        .TAPS    (TAPS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_pixel_count (job_pixel_count),
        .coeffs_valid    (coeffs_valid),
        .coeffs_ready    (coeffs_ready),
        .coeffs_data     (coeffs_data),
        .win_valid       (win_valid),
        .win_ready       (win_ready),
        .win_data        (win_data),
        .mac_valid       (mac_valid),
        .mac_ready       (mac_ready),
        .mac_window      (mac_window),
        .mac_coeffs      (mac_coeffs),
        .mac_last        (mac_last),
        .done_valid      (done_valid),
        .done_ready      (done_ready),
        .done_count      (done_count),
        .done_stalls     (done_stalls)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIN_BITS-1:0] rand_win();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[WIN_BITS-1:0];
    endfunction

    // win_mode : 0 = windows always offered, 1 = random gaps
    // ready_mode: 0 = mac_ready always 1, 1 = random, 2 = two-cycle stall on beat 2
    // abort_at : >= 0 applies rst once that many beats were delivered
    // ramp     : 1 = coefficients 0..8, 0 = random coefficients
    task automatic run_job(input int n, input int win_mode, input int ready_mode,
                           input int abort_at, input bit ramp);
        logic [WIN_BITS-1:0] q[$];
        logic [WIN_BITS-1:0] exp_w;
        logic [WIN_BITS-1:0] held_w;
        logic [CF_BITS-1:0]  cf;
        logic [31:0]         exp_stalls;
        int accepted, delivered, stalls, guard, held, budget, wait_n;
        bit prev_stall, take;

        for (int i = 0; i < TAPS; i++) begin
            if (ramp) cf[i*COEFF_W +: COEFF_W] = COEFF_W'(i);
            else      cf[i*COEFF_W +: COEFF_W] = COEFF_W'($urandom());
        end

        // IDLE: job, early coefficient bundle and an early window all offered.
        job_valid       = 1'b1;
        job_pixel_count = CNT_W'(n);
        coeffs_valid    = 1'b1;
        coeffs_data     = cf;
        win_valid       = 1'b1;
        win_data        = rand_win();
        mac_ready       = 1'b1;
        done_ready      = 1'b0;
        #1;
        chk("idle_job_ready", 128'(job_ready), 128'(1));
        chk("idle_coeffs_ready", 128'(coeffs_ready), 128'(0));
        chk("idle_win_ready", 128'(win_ready), 128'(0));
        step();
        job_valid       = 1'b0;
        job_pixel_count = CNT_W'($urandom());
        #1;
        chk("coeff_ready", 128'(coeffs_ready), 128'(1));
        chk("coeff_job_ready", 128'(job_ready), 128'(0));
        chk("coeff_win_ready", 128'(win_ready), 128'(0));
        step();
        coeffs_valid = 1'b0;
        coeffs_data  = {CF_BITS{1'b1}};
        #1;
        chk("coeffs_latched", 128'(mac_coeffs), 128'(cf));

        accepted   = 0;
        delivered  = 0;
        stalls     = 0;
        guard      = 0;
        held       = 0;
        prev_stall = 1'b0;
        held_w     = '0;
        budget     = n * 8 + 100;
        while (delivered < n && guard < budget) begin
            guard++;
            case (ready_mode)
                0: mac_ready = 1'b1;
                1: mac_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (mac_valid && delivered == 1 && held < 2) begin
                        mac_ready = 1'b0;
                        held++;
                    end else begin
                        mac_ready = 1'b1;
                    end
                end
            endcase
            #1;
            chk("occupancy", 128'(mac_valid), 128'(q.size() == 1));
            if (prev_stall) chk("hold_window", 128'(mac_window), 128'(held_w));
            if (mac_valid && !mac_ready) chk("stall_win_ready", 128'(win_ready), 128'(0));
            if (accepted >= n) chk("extra_win_ready", 128'(win_ready), 128'(0));
            if (win_mode == 0 && ready_mode == 0 && delivered > 0)
                chk("throughput", 128'(mac_valid), 128'(1));
            take       = win_valid && win_ready;
            prev_stall = mac_valid && !mac_ready;
            held_w     = mac_window;
            if (mac_valid && mac_ready) begin
                if (q.size() > 0) exp_w = q.pop_front();
                else              exp_w = '0;
                chk("beat_window", 128'(mac_window), 128'(exp_w));
                chk("beat_coeffs", 128'(mac_coeffs), 128'(cf));
                chk("beat_last", 128'(mac_last), 128'(delivered + 1 == n));
                delivered++;
            end
            if (mac_valid && !mac_ready) stalls++;
            if (take) begin
                q.push_back(win_data);
                accepted++;
            end
            step();
            if (abort_at >= 0 && delivered == abort_at) break;
            if (take || !win_valid) begin
                win_valid = (win_mode == 0) || ($urandom_range(0, 1) == 1);
                if (win_valid) win_data = rand_win();
            end
        end

        if (abort_at >= 0) begin
            rst       = 1'b1;
            win_valid = 1'b0;
            mac_ready = 1'b1;
            step();
            rst = 1'b0;
            #1;
            chk("abort_state", 128'(delivered), 128'(abort_at));
            chk("abort_mac_valid", 128'(mac_valid), 128'(0));
            chk("abort_done_valid", 128'(done_valid), 128'(0));
            chk("abort_job_ready", 128'(job_ready), 128'(1));
            chk("abort_mac_last", 128'(mac_last), 128'(0));
            chk("abort_done_count", 128'(done_count), 128'(0));
            chk("abort_mac_window", 128'(mac_window), 128'(0));
            chk("abort_mac_coeffs", 128'(mac_coeffs), 128'(0));
            return;
        end

        chk("run_timeout", 128'(delivered < n), 128'(0));

`ifdef FILTER_JOB_CTRL_STALL_CNT_EN
        exp_stalls = 32'(stalls);
`else
        exp_stalls = 32'd0;
`endif

        // One cycle after the final accept: done token must be up.
        if (!win_valid) begin
            win_valid = 1'b1;
            win_data  = rand_win();
        end
        mac_ready = 1'b1;
        #1;
        chk("done_valid", 128'(done_valid), 128'(1));
        chk("done_count", 128'(done_count), 128'(n));
        chk("done_stalls", 128'(done_stalls), 128'(exp_stalls));
        chk("done_mac_valid", 128'(mac_valid), 128'(0));
        chk("done_win_ready", 128'(win_ready), 128'(0));
        chk("done_job_ready", 128'(job_ready), 128'(0));
        wait_n = $urandom_range(0, 2);
        for (int k = 0; k < wait_n; k++) begin
            step();
            #1;
            chk("done_hold", 128'(done_valid), 128'(1));
        end
        done_ready = 1'b1;
        #1;
        chk("done_xfer_job_ready", 128'(job_ready), 128'(0));
        step();
        done_ready = 1'b0;
        win_valid  = 1'b0;
        #1;
        chk("idle_after_done", 128'(job_ready), 128'(1));
        chk("done_dropped", 128'(done_valid), 128'(0));
    endtask

    initial begin
        rst             = 1'b1;
        job_valid       = 1'b0;
        job_pixel_count = '0;
        coeffs_valid    = 1'b0;
        coeffs_data     = '0;
        win_valid       = 1'b0;
        win_data        = '0;
        mac_ready       = 1'b0;
        done_ready      = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("rst_job_ready", 128'(job_ready), 128'(1));
        chk("rst_coeffs_ready", 128'(coeffs_ready), 128'(0));
        chk("rst_win_ready", 128'(win_ready), 128'(0));
        chk("rst_mac_valid", 128'(mac_valid), 128'(0));
        chk("rst_done_valid", 128'(done_valid), 128'(0));
        chk("rst_mac_window", 128'(mac_window), 128'(0));
        chk("rst_mac_coeffs", 128'(mac_coeffs), 128'(0));
        chk("rst_mac_last", 128'(mac_last), 128'(0));
        chk("rst_done_count", 128'(done_count), 128'(0));
        chk("rst_done_stalls", 128'(done_stalls), 128'(0));

        run_job(4, 0, 0, -1, 1'b1);
        run_job(0, 0, 0, -1, 1'b1);
        run_job(3, 0, 2, -1, 1'b0);
        run_job(5, 0, 0, 2, 1'b0);
        run_job(1, 0, 0, -1, 1'b0);
        for (int j = 0; j < 12; j++) begin
            run_job(int'($urandom_range(0, 12)), 1, 1, -1, 1'b0);
        end
        run_job(32'h0000_FFFF, 0, 0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
